muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer for the MIPS datapath's HI/LO instructions (mult, multu, div, divu). It shares the R-type funct decode space with the ALU control path. It accepts one operation at a time from the decode stage, runs it over a fixed number of shift-add or shift-subtract cycles, and writes the result to internal HI/LO registers. `busy_o` stalls the issuing stage while an operation is in progress.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits.

- `clk_i`  in  1: clock; all state updates on its rising edge.
- `rst_i`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: request; sampled only in IDLE.
- `funct_i`  in  6: operation select. The recognised codes are:
  - `6'b011000` mult
  - `6'b011001` multu
  - `6'b011010` div
  - `6'b011011` divu
- `src1_i`  in  WIDTH: multiplicand or dividend (rs).
- `src2_i`  in  WIDTH: multiplier or divisor (rt).
- `busy_o`  out  1: operation in progress.
- `done_o`  out  1: one-cycle pulse; HI/LO were updated on this cycle's opening edge.
- `err_o`  out  1: divide by zero; valid only while `done_o` is high.
- `hi_o`  out  WIDTH: HI register.
- `lo_o`  out  WIDTH: LO register.

## Operation
- **States:** IDLE, LOAD, CALC, SIGN.
- **Accepting a request:** in IDLE, `start_i` high with a recognised funct captures funct, `src1_i` and `src2_i`, then moves to LOAD.
  - An unrecognised funct is ignored; the block stays in IDLE and `busy_o` stays low.
  - `start_i` is ignored in every state other than IDLE.
- **LOAD:**
  - Signed ops (mult, div): take the magnitudes of both operands. Record the result sign (operand signs XOR) and the remainder sign (dividend sign).
  - Unsigned ops: signs are forced positive.
  - div/divu with a zero divisor: skip CALC, go straight to SIGN with the error flag set.
  - Otherwise: clear the iteration counter and move to CALC.
- **CALC:** runs exactly WIDTH iterations, one per cycle; the counter is $clog2(WIDTH)+1 bits. Leave for SIGN after iteration WIDTH.
  - Multiply: radix-2 shift-add into a 2·WIDTH-bit accumulator.
  - Divide: restoring shift-subtract. Quotient bits are built in the low half and the partial remainder in the high half.
- **SIGN:** corrects the sign of the unsigned result, writes HI/LO, pulses `done_o`, and returns to IDLE.
  - Multiply: if the result sign is negative, negate the full 2·WIDTH-bit product (two's complement). Result goes to {HI, LO}.
  - Divide: if the result sign is negative, negate the quotient; if the remainder sign is negative, negate the remainder. Quotient goes to LO, remainder to HI.
  - Divide by zero: LO = all ones, HI = original dividend (unmodified), `err_o` = 1.
- **Overflow case:** div with dividend −2^(WIDTH−1) and divisor −1 gives LO = 0x8000_0000 and HI = 0 (wraps, no error).
- **Output hold:** HI/LO hold their values until the next SIGN write.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH per half. Magnitudes are unsigned WIDTH-bit values, so |−2^(WIDTH−1)| is representable.

## Timing
- Edge numbering: E0 is the edge that samples an accepted `start_i`; E1, E2, … follow.
  - E1: LOAD.
  - E2 through E(WIDTH+1): CALC iterations.
  - E(WIDTH+2): SIGN.
- Latency:
  - Normal operation: `done_o` is high in the cycle after edge E(WIDTH+2), i.e. WIDTH+2 cycles after acceptance (34 for WIDTH=32).
  - Divide by zero: `done_o` is high in the cycle after E2.
- `busy_o` is high from after E0 until the edge that writes HI/LO, and low in the `done_o` cycle. A new start may therefore be accepted in the `done_o` cycle itself.
- `done_o` and `err_o` are registered outputs and last exactly one cycle.
- Reset values: state IDLE, `busy_o` 0, `done_o` 0, `err_o` 0, `hi_o` 0, `lo_o` 0, counter 0.
- Reset asserted mid-operation aborts immediately. The outputs take their reset values, no `done_o` is produced, and the partial result is discarded.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- **Defined:** div and divu are implemented as described above.
- **Undefined:**
  - The divide datapath, remainder-sign logic and zero check are compiled out.
  - Funct codes `011010` and `011011` are treated as unrecognised, so start is ignored.
  - `err_o` is tied to 0.
  - Multiply behaviour and timing are unchanged.

## Test plan
All scenarios use WIDTH=32.
1. **Signed multiply:** mult, src1=7, src2=0xFFFF_FFFD (−3) -> `done_o` 34 cycles after E0; HI=0xFFFF_FFFF, LO=0xFFFF_FFEB; `err_o`=0.
2. **Unsigned multiply:** multu, 0xFFFF_FFFF × 0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001.
3. **Signed divide:** div, src1=0xFFFF_FFF9 (−7), src2=2 -> LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1). Then div 0x8000_0000 by 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
4. **Divide by zero:** divu, src1=0x64, src2=0 -> `done_o` 2 cycles after E0 with `err_o`=1; LO=0xFFFF_FFFF, HI=0x0000_0064.
5. **Request and reset handling:**
   - Start multu 3×5. Assert `start_i` with mult 9×9 at cycle 10 -> ignored; result HI=0, LO=15.
   - Start again and pull `rst_i` low at cycle 12 -> `busy_o`, HI and LO are 0 at once, and no `done_o` follows.
6. **Macro undefined, plus back-to-back issue:**
   - With `MULDIV_DIV_EN` undefined: start with div -> `busy_o` stays 0; HI/LO unchanged.
   - Back-to-back: a mult issued in the `done_o` cycle of a previous mult is accepted, and the next `done_o` follows 34 cycles later.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative HI/LO multiply/divide sequencer for mult/multu/div/divu; divide support built only with MULDIV_DIV_EN.
// Latency: done_o pulses WIDTH+2 cycles after acceptance (2 cycles for divide by zero).
// Backpressure: busy_o high while an operation runs; start_i is ignored unless IDLE, a new start is taken in the done_o cycle.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef MULDIV_DIV_EN
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        SIGN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic             funct_ok;
    logic             accept;
    logic             op_signed;
    logic             res_neg;
    logic [WIDTH-1:0] op_a;      // raw dividend/multiplicand, kept for the div-by-zero HI value
    logic [WIDTH-1:0] op_b;      // raw src2 until LOAD, its magnitude afterwards
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     mul_sum;
    logic [CW-1:0]      cnt;
    logic               div_zero;

`ifdef MULDIV_DIV_EN
    logic               op_div;
    logic               rem_neg;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_nxt;
`endif

    // Decode which funct codes start an operation in this build.
    always_comb begin
        funct_ok = (funct_i == F_MULT) || (funct_i == F_MULTU);
`ifdef MULDIV_DIV_EN
        if ((funct_i == F_DIV) || (funct_i == F_DIVU)) begin
            funct_ok = 1'b1;
        end
`endif
    end

    assign accept = (state == IDLE) && start_i && funct_ok;
    assign busy_o = (state != IDLE);

    assign mag_a = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;

`ifdef MULDIV_DIV_EN
    assign div_zero = op_div && (op_b == '0);
`else
    assign div_zero = 1'b0;
`endif

    // One iteration of shift-add multiply or restoring shift-subtract divide.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
        mul_nxt = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, op_b};
        if (div_diff[WIDTH]) begin
            div_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            div_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
        acc_nxt = op_div ? div_nxt : mul_nxt;
`else
        acc_nxt = mul_nxt;
`endif
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: divide by zero bypasses CALC, CALC exits after WIDTH iterations.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: state_nxt = div_zero ? SIGN : CALC;
            CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = SIGN;
            SIGN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath, sign correction and HI/LO write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            res_neg   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            hi_o      <= '0;
            lo_o      <= '0;
`ifdef MULDIV_DIV_EN
            op_div    <= 1'b0;
            rem_neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a      <= src1_i;
                        op_b      <= src2_i;
                        op_signed <= ~funct_i[0];
`ifdef MULDIV_DIV_EN
                        op_div    <= funct_i[1];
`endif
                    end
                end
                LOAD: begin
                    op_b    <= mag_b;
                    res_neg <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                    rem_neg <= op_signed & op_a[WIDTH-1];
`endif
                    acc     <= {{WIDTH{1'b0}}, mag_a};
                    cnt     <= '0;
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                end
                SIGN: begin
`ifdef MULDIV_DIV_EN
                    if (op_div) begin
                        if (div_zero) begin
                            lo_o <= '1;
                            hi_o <= op_a;
                        end else begin
                            lo_o <= res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                            hi_o <= rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                        end
                    end else
`endif
                    begin
                        {hi_o, lo_o} <= res_neg ? -acc : acc;
                    end
                end
                default: ;
            endcase
        end
    end

    // done_o/err_o are registered one-cycle pulses aligned with the HI/LO write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            done_o <= 1'b0;
`ifdef MULDIV_DIV_EN
            err_o  <= 1'b0;
`endif
        end else begin
            done_o <= (state == SIGN);
`ifdef MULDIV_DIV_EN
            err_o  <= (state == SIGN) && div_zero;
`endif
        end
    end

`ifndef MULDIV_DIV_EN
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (WIDTH=32) with a scoreboard of expected HI/LO/err/latency.
// Divide scenarios are exercised when MULDIV_DIV_EN is defined; otherwise div codes must be ignored.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_muldiv_seq;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i = 1'b0;
    logic [5:0]  funct_i = '0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_seen = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .funct_i (funct_i),
        .src1_i  (src1_i),
        .src2_i  (src2_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (done_o === 1'b1) done_seen++;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the sampling edge E0.
    task automatic issue(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic accept, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic eerr, input int elat);
        exp_t e;
        funct_i = f;
        src1_i  = a;
        src2_i  = b;
        start_i = 1'b1;
        if (accept) begin
            e = '{ehi, elo, eerr, elat};
            sbq.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
        cyc = 0;
        check({tag, " busy"}, 64'(busy_o), 64'(accept));
        check({tag, " done low"}, 64'(done_o), 64'(0));
    endtask

    // Returns at the falling edge inside the done_o cycle.
    task automatic wait_done(input string tag);
        exp_t e;
        while (done_o !== 1'b1 && cyc < 200) step(1);
        check({tag, " done seen"}, 64'(done_o), 64'(1));
        check({tag, " sb entry"}, 64'(sbq.size() != 0), 64'(1));
        if (done_o === 1'b1 && sbq.size() != 0) begin
            e = sbq.pop_front();
            check({tag, " latency"}, 64'(cyc), 64'(e.lat));
            check({tag, " hi"}, 64'(hi_o), 64'(e.hi));
            check({tag, " lo"}, 64'(lo_o), 64'(e.lo));
            check({tag, " err"}, 64'(err_o), 64'(e.err));
            check({tag, " busy low"}, 64'(busy_o), 64'(0));
            last_hi = e.hi;
            last_lo = e.lo;
        end
    endtask

    function automatic logic [63:0] mul_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic signed [63:0] p;
        if (sgn) begin
            x = {{32{a[31]}}, a};
            y = {{32{b[31]}}, b};
            p = x * y;
            return p;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

`ifdef MULDIV_DIV_EN
    // Returns {remainder, quotient} with quotient truncated toward zero.
    function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        logic signed [63:0] q;
        logic signed [63:0] r;
        if (sgn) begin
            x = {{32{a[31]}}, a};
            y = {{32{b[31]}}, b};
        end else begin
            x = {32'b0, a};
            y = {32'b0, b};
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction
`endif

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] m;

        // Reset state.
        rst_i = 1'b1;
        #1 rst_i = 1'b0;
        #10;
        check("rst busy", 64'(busy_o), 64'(0));
        check("rst done", 64'(done_o), 64'(0));
        check("rst err", 64'(err_o), 64'(0));
        check("rst hi", 64'(hi_o), 64'(0));
        check("rst lo", 64'(lo_o), 64'(0));
        @(negedge clk);
        rst_i = 1'b1;
        step(2);

        // Signed and unsigned multiply; each issue happens in the previous done_o cycle.
        issue("mult 7x-3", F_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
        wait_done("mult 7x-3");
        issue("multu max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
        wait_done("multu max");
        issue("mult minxmin", F_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0, 1'b0, 34);
        wait_done("mult minxmin");
        issue("mult x0", F_MULT, 32'hFFFF_FFF0, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 34);
        wait_done("mult x0");
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            m = mul_model(i[0] == 1'b0, a, b);
            issue("mult rand", (i[0] == 1'b0) ? F_MULT : F_MULTU, a, b, 1'b1, m[63:32], m[31:0], 1'b0, 34);
            wait_done("mult rand");
        end

`ifdef MULDIV_DIV_EN
        issue("div -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        wait_done("div -7/2");
        issue("div ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0, 34);
        wait_done("div ovf");
        issue("divu by0", F_DIVU, 32'h64, 32'h0, 1'b1, 32'h64, 32'hFFFF_FFFF, 1'b1, 2);
        wait_done("divu by0");
        issue("div by0 neg", F_DIV, 32'hFFFF_FF00, 32'h0, 1'b1, 32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, 2);
        wait_done("div by0 neg");
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (b == 32'h0) b = 32'h1;
            m = div_model(i[0] == 1'b0, a, b);
            issue("div rand", (i[0] == 1'b0) ? F_DIV : F_DIVU, a, b, 1'b1, m[63:32], m[31:0], 1'b0, 34);
            wait_done("div rand");
        end
        step(1);
`else
        step(1);
        issue("div off", F_DIV, 32'd100, 32'd7, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        step(2);
        check("div off busy", 64'(busy_o), 64'(0));
        check("div off hi", 64'(hi_o), 64'(last_hi));
        check("div off lo", 64'(lo_o), 64'(last_lo));
`endif

        // Unrecognised funct is ignored.
        issue("bad funct", 6'b100000, 32'd5, 32'd5, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        step(2);
        check("bad funct busy", 64'(busy_o), 64'(0));
        check("bad funct hi", 64'(hi_o), 64'(last_hi));
        check("bad funct lo", 64'(lo_o), 64'(last_lo));

        // start_i while busy is ignored.
        issue("multu 3x5", F_MULTU, 32'd3, 32'd5, 1'b1, 32'h0, 32'd15, 1'b0, 34);
        step(9);
        funct_i = F_MULT;
        src1_i  = 32'd9;
        src2_i  = 32'd9;
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
        check("ignored start busy", 64'(busy_o), 64'(1));
        wait_done("multu 3x5");
        step(1);

        // Reset mid-operation aborts with no done_o.
        issue("abort", F_MULTU, 32'd3, 32'd5, 1'b1, 32'h0, 32'd15, 1'b0, 34);
        void'(sbq.pop_back());
        step(11);
        rst_i = 1'b0;
        #1;
        check("abort busy", 64'(busy_o), 64'(0));
        check("abort hi", 64'(hi_o), 64'(0));
        check("abort lo", 64'(lo_o), 64'(0));
        check("abort done", 64'(done_o), 64'(0));
        done_seen = 0;
        step(2);
        rst_i = 1'b1;
        step(40);
        check("abort no done", 64'(done_seen), 64'(0));
        check("abort idle", 64'(busy_o), 64'(0));

        // Recovery after reset.
        issue("mult recover", F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h1, 1'b0, 34);
        wait_done("mult recover");
        step(1);
        check("done one cycle", 64'(done_o), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
